// File: rtl/jtdd_obj_romslot_if.sv
// Client fetch port and SDRAM arbiter port of one object-layer ROM slot.
interface jtdd_obj_romslot_if #(
    parameter int AW  = 19,
    parameter int SDW = 22
);
    logic           cs;
    logic [AW-1:0]  addr;
    logic [15:0]    dout;
    logic           ok;
    logic           sdram_req;
    logic [SDW-1:0] sdram_addr;
    logic           sdram_ack;
    logic           sdram_rdy;
    logic [15:0]    sdram_din;

    modport slave (
        input  cs, addr, sdram_ack, sdram_rdy, sdram_din,
        output dout, ok, sdram_req, sdram_addr
    );

    modport master (
        output cs, addr, sdram_ack, sdram_rdy, sdram_din,
        input  dout, ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtdd_obj_romslot.sv
// Object-layer graphics ROM slot: two-entry tagged cache in front of the SDRAM
// arbiter, with optional next-word prefetch while idle.
module jtdd_obj_romslot #(
    parameter int             AW       = 19,
    parameter int             SDW      = 22,
    parameter logic [SDW-1:0] OFFSET   = {SDW{1'b0}},
    parameter bit             PREFETCH = 1'b1
) (
    input logic               clk,
    input logic               rst,
    jtdd_obj_romslot_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [1:0]     valid_r;
    logic [AW-1:0]  tag_r [2];
    logic [15:0]    data_r [2];
    logic           lru_r;
    logic [AW-1:0]  pend_r;
    logic           req_r;
    logic [SDW-1:0] sdaddr_r;
    logic [15:0]    dout_r;

    logic [1:0]     hit_s;
    logic [1:0]     nxhit_s;
    logic           any_hit_s;
    logic           hit_idx_s;
    logic           nx_miss_s;
    logic [AW-1:0]  addr_nx_s;
    logic [15:0]    dout_s;
    logic           launch_s;
    logic [AW-1:0]  launch_addr_s;
    logic           ack_take_s;
    logic           fill_s;
    logic           victim_s;

    function automatic logic [SDW-1:0] sd_addr(input logic [AW-1:0] a);
        return SDW'(a) + OFFSET;
    endfunction

    // Tag compare for the client address and its wrapping successor
    always_comb begin
        addr_nx_s = bus.addr + {{(AW-1){1'b0}}, 1'b1};
        for (int i = 0; i < 2; i++) begin
            hit_s[i]   = valid_r[i] && (tag_r[i] == bus.addr);
            nxhit_s[i] = valid_r[i] && (tag_r[i] == addr_nx_s);
        end
        any_hit_s = |hit_s;
        hit_idx_s = hit_s[1];
        nx_miss_s = ~|nxhit_s;
        dout_s    = any_hit_s ? data_r[hit_idx_s] : dout_r;
    end

    assign bus.ok         = bus.cs & any_hit_s;
    assign bus.dout       = dout_s;
    assign bus.sdram_req  = req_r;
    assign bus.sdram_addr = sdaddr_r;

    // Next-state and request launch; demand misses outrank prefetch
    always_comb begin
        state_s       = state_r;
        launch_s      = 1'b0;
        launch_addr_s = pend_r;
        ack_take_s    = 1'b0;
        fill_s        = 1'b0;
        // the fill never lands on the entry the client is reading right now
        victim_s      = (bus.cs && any_hit_s) ? ~hit_idx_s : lru_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cs && !any_hit_s) begin
                    launch_s      = 1'b1;
                    launch_addr_s = bus.addr;
                    state_s       = ST_REQ;
                end else if (PREFETCH && bus.cs && any_hit_s && nx_miss_s) begin
                    launch_s      = 1'b1;
                    launch_addr_s = addr_nx_s;
                    state_s       = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    ack_take_s = 1'b1;
                    state_s    = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.sdram_rdy) begin
                    fill_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, request port, valid bits and replacement pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            req_r    <= 1'b0;
            sdaddr_r <= {SDW{1'b0}};
            pend_r   <= {AW{1'b0}};
            valid_r  <= 2'b00;
            lru_r    <= 1'b0;
            dout_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            dout_r  <= dout_s;
            if (launch_s) begin
                pend_r   <= launch_addr_s;
                sdaddr_r <= sd_addr(launch_addr_s);
                req_r    <= 1'b1;
            end else if (ack_take_s) begin
                req_r <= 1'b0;
            end
            if (fill_s) begin
                valid_r[victim_s] <= 1'b1;
                lru_r             <= ~victim_s;
            end else if (bus.cs && any_hit_s) begin
                lru_r <= ~hit_idx_s;
            end
        end
    end

    // Cache payload; meaningless until the matching valid bit is set
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[victim_s]  <= pend_r;
            data_r[victim_s] <= bus.sdram_din;
        end
    end
endmodule
